comma_wide: RTL

//  - Parametrised successor to the single-byte comma: appends a 1/2/4-byte value, or zero-pad

---
 rtl/forthsuper_pkg.sv | 28 ++
 rtl/mb8_io.sv | 13 +
 rtl/comma_bsel.sv | 16 +
 rtl/comma_wide.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/forthsuper_pkg.sv
// Shared types for the forthsuper dictionary/compiler blocks.
// Holds the comma_wide state and mode encodings plus the mode-to-byte-count helper.
package forthsuper_pkg;

    typedef enum logic [1:0] {
        CW_IDLE = 2'd0,
        CW_WR   = 2'd1,
        CW_DONE = 2'd2
    } comma_wide_sts;

    typedef enum logic [1:0] {
        CW_B1  = 2'd0,
        CW_B2  = 2'd1,
        CW_B4  = 2'd2,
        CW_PAD = 2'd3
    } comma_mode;

    // Byte count for the value-storing modes; PAD is sized from the address instead.
    function automatic logic [2:0] mode_bytes(input comma_mode m);
        case (m)
            CW_B1:   return 3'd1;
            CW_B2:   return 3'd2;
            CW_B4:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mb8_io.sv
// Byte-wide memory bus: write enable, address, write data and read data.
// The master drives we/ai/vi; vo flows back from the memory.
interface mb8_io #(parameter int ASZ = 17);

    logic           we;
    logic [ASZ-1:0] ai;
    logic [7:0]     vi;
    logic [7:0]     vo;

    modport master (output we, output ai, output vi);
    modport slave  (input we, input ai, input vi, output vo);

endinterface

// File: rtl/comma_bsel.sv
// Combinational byte-lane select: returns byte k of a little-endian data word.
// Lanes beyond the word width read as zero.
module comma_bsel #(
    parameter int DSZ = 32
) (
    input  logic [DSZ-1:0] data,
    input  logic [2:0]     k,
    output logic [7:0]     lane
);

    logic [DSZ-1:0] shifted;

    assign shifted = data >> {k, 3'b000};
    assign lane    = shifted[7:0];

endmodule

// File: rtl/comma_wide.sv
// Appends a 1/2/4-byte value, or zero-fill up to an ALN boundary, at HERE,
// one byte per clock over an mb8_io master, then reports the updated HERE.
module comma_wide #(
    parameter int DSZ = 32,
    parameter int ASZ = 17,
    parameter int ALN = 4
) (
    input  logic           clk,
    input  logic           rst,
    mb8_io.master          mb_if,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [ASZ-1:0] ai,
    input  logic [DSZ-1:0] vi,
    output logic [ASZ-1:0] here_o,
    output logic           bsy,
    output logic           done,
    output logic           err,
    output logic [1:0]     st
);

    import forthsuper_pkg::*;

    localparam logic [2:0] ALN_MASK  = 3'(ALN - 1);
    localparam logic [2:0] ALN_LOW   = 3'(ALN);
    localparam logic [5:0] DSZ_BITS  = 6'(DSZ);

    comma_wide_sts  state, state_nxt;
    comma_mode      mode_e;
    logic [ASZ-1:0] addr_q;
    logic [DSZ-1:0] data_q;
    logic           pad_q;
    logic [2:0]     n_q, k_q;

    logic           accept, reject, last;
    logic [2:0]     pad_gap, n_req;
    logic [2:0]     wr_k;
    logic [DSZ-1:0] wr_data;
    logic [ASZ-1:0] wr_addr;
    logic           wr_pad;
    logic [7:0]     lane;

    logic           we_nxt, bsy_nxt, done_nxt, err_nxt;
    logic [ASZ-1:0] ai_nxt, here_nxt;
    logic [7:0]     vi_nxt;

    assign mode_e  = comma_mode'(mode);
    assign accept  = start && (state != CW_WR);
    // Distance to the next boundary, modulo ALN (zero when already aligned).
    assign pad_gap = (ALN_LOW - (ai[2:0] & ALN_MASK)) & ALN_MASK;
    assign n_req   = (mode_e == CW_PAD) ? pad_gap : mode_bytes(mode_e);
    assign reject  = (mode_e != CW_PAD) && ({n_req, 3'b000} > DSZ_BITS);
    assign last    = (k_q == n_q - 3'd1);
    assign st      = state;

    // Byte 0 comes straight from the request inputs; later bytes from the latched copy.
    assign wr_k    = accept ? 3'd0 : k_q + 3'd1;
    assign wr_data = accept ? vi : data_q;
    assign wr_addr = accept ? ai : addr_q;
    assign wr_pad  = accept ? (mode_e == CW_PAD) : pad_q;

    comma_bsel #(.DSZ(DSZ)) u_bsel (
        .data (wr_data),
        .k    (wr_k),
        .lane (lane)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CW_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = CW_IDLE;
        case (state)
            CW_IDLE, CW_DONE: begin
                if (accept) state_nxt = (reject || n_req == 3'd0) ? CW_DONE : CW_WR;
            end
            CW_WR:   state_nxt = last ? CW_DONE : CW_WR;
            default: state_nxt = CW_IDLE;
        endcase
    end

    always_comb begin
        we_nxt   = 1'b0;
        bsy_nxt  = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        ai_nxt   = mb_if.ai;
        vi_nxt   = mb_if.vi;
        here_nxt = here_o;
        case (state)
            CW_IDLE, CW_DONE: begin
                if (accept) begin
                    if (reject || n_req == 3'd0) begin
                        done_nxt = 1'b1;
                        err_nxt  = reject;
                        here_nxt = ai;
                    end else begin
                        we_nxt  = 1'b1;
                        bsy_nxt = 1'b1;
                        ai_nxt  = wr_addr + ASZ'(wr_k);
                        vi_nxt  = wr_pad ? 8'h00 : lane;
                    end
                end
            end
            CW_WR: begin
                if (last) begin
                    done_nxt = 1'b1;
                    here_nxt = addr_q + ASZ'(n_q);
                end else begin
                    we_nxt  = 1'b1;
                    bsy_nxt = 1'b1;
                    ai_nxt  = wr_addr + ASZ'(wr_k);
                    vi_nxt  = wr_pad ? 8'h00 : lane;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_if.we <= 1'b0;
            mb_if.ai <= '0;
            mb_if.vi <= 8'h00;
            bsy      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            here_o   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            pad_q    <= 1'b0;
            n_q      <= 3'd0;
            k_q      <= 3'd0;
        end else begin
            mb_if.we <= we_nxt;
            mb_if.ai <= ai_nxt;
            mb_if.vi <= vi_nxt;
            bsy      <= bsy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            here_o   <= here_nxt;
            if (accept) begin
                addr_q <= ai;
                data_q <= vi;
                pad_q  <= (mode_e == CW_PAD);
                n_q    <= n_req;
                k_q    <= 3'd0;
            end else if (state == CW_WR) begin
                k_q    <= k_q + 3'd1;
            end
        end
    end

endmodule
